// File: rtl/poly_div_gf2_seq.sv
// Bit-serial GF(2) polynomial long divider: A = Q*B xor R, one quotient bit per clock.
// The divisor is first left-justified (NORM), then subtracted (xor) down the dividend (DIV).
module poly_div_gf2_seq #(
  parameter int unsigned DW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-2:0]   a,
  input  logic [DW-1:0]     b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-2:0]   q,
  output logic [DW-2:0]     r,
  output logic              div_by_zero
);

  localparam int unsigned AW = 2 * DW - 1;
  localparam int unsigned SW = $clog2(AW);
  localparam logic [SW-1:0] TOP = SW'(AW - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StNorm = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_rem;
  logic [AW-1:0] r_den;
  logic [AW-1:0] r_quo;
  logic [SW-1:0] r_s;
  logic [SW-1:0] r_cnt;
  logic [AW-1:0] r_q;
  logic [DW-2:0] r_r;
  logic          r_dbz;

  logic [SW-1:0] w_p;
  logic          w_qbit;
  logic [AW-1:0] w_rem_nx;
  logic [AW-1:0] w_quo_nx;

  // Bit p of the partial remainder lines up with the current top of the shifted divisor.
  always_comb begin
    w_p      = TOP - (r_s - r_cnt);
    w_qbit   = r_rem[w_p];
    w_rem_nx = w_qbit ? (r_rem ^ r_den) : r_rem;
    w_quo_nx = {r_quo[AW-2:0], w_qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_rem   <= '0;
      r_den   <= '0;
      r_quo   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_rem <= a;
            r_den <= {b, {(DW - 1){1'b0}}};
            r_s   <= SW'(DW - 1);
            if (b == '0) begin
              r_q     <= '0;
              r_r     <= '0;
              r_dbz   <= 1'b1;
              r_state <= StDone;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= StNorm;
            end
          end
        end
        StNorm: begin
          if (r_den[AW-1]) begin
            r_cnt   <= r_s;
            r_quo   <= '0;
            r_state <= StDiv;
          end else begin
            r_den <= r_den << 1;
            r_s   <= r_s + 1'b1;
          end
        end
        StDiv: begin
          r_rem <= w_rem_nx;
          r_den <= r_den >> 1;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_q     <= w_quo_nx;
            r_r     <= w_rem_nx[DW-2:0];
            r_state <= StDone;
          end
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = (r_state == StDone);
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_poly_div_gf2_seq.sv
// Bench for poly_div_gf2_seq: directed cases, backpressure, async reset, full a/b sweep.
// Expected results come from an independent long-division model via a scoreboard queue.
module tb_poly_div_gf2_seq;

  localparam int DW = 4;
  localparam int AW = 2 * DW - 1;
  localparam int PW = AW + DW - 1;

  typedef struct {
    logic [AW-1:0] q;
    logic [DW-2:0] r;
    logic          dbz;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] q;
  logic [DW-2:0] r;
  logic          div_by_zero;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  poly_div_gf2_seq #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int deg(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Textbook long division; latency counts edges after the accept edge.
  function automatic exp_t model(input logic [AW-1:0] aa, input logic [DW-1:0] bb);
    exp_t          e;
    logic [AW-1:0] rem;
    int            db;
    e.q = '0; e.r = '0; e.dbz = (bb == '0); e.lat = 0;
    if (bb == '0) return e;
    db  = deg(32'(bb));
    rem = aa;
    for (int i = AW - 1; i >= db; i--) begin
      if (rem[i]) begin
        e.q[i-db] = 1'b1;
        rem = rem ^ (AW'(bb) << (i - db));
      end
    end
    e.r   = rem[DW-2:0];
    e.lat = 3 * DW - 1 - 2 * db;
    return e;
  endfunction

  function automatic logic [PW-1:0] mul(input logic [AW-1:0] qq, input logic [DW-1:0] bb);
    logic [PW-1:0] p = '0;
    for (int i = 0; i < AW; i++) if (qq[i]) p = p ^ (PW'(bb) << i);
    return p;
  endfunction

  task automatic send(input logic [AW-1:0] aa, input logic [DW-1:0] bb);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = aa;
    b = bb;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb.push_back(model(aa, bb));
  endtask

  task automatic wait_result(input bit chk_lat, input logic [AW-1:0] aa, input logic [DW-1:0] bb);
    exp_t e;
    int   n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (chk_lat) chk("latency", 32'(n), 32'(e.lat));
      chk("q", 32'(q), 32'(e.q));
      chk("r", 32'(r), 32'(e.r));
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      if (bb != '0) begin
        chk("roundtrip", 32'(mul(q, bb) ^ PW'(r)), 32'(aa));
        chk("deg_r_lt_deg_b", 32'(deg(32'(r)) < deg(32'(bb))), 32'd1);
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] hq;
    logic [DW-2:0] hr;
    logic [AW-1:0] ra;
    logic [DW-1:0] rb;

    #12 chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    send(7'b1010101, 4'b1011);
    wait_result(1'b1, 7'b1010101, 4'b1011);
    chk("ex1_q_const", 32'(q), 32'b0001001);
    chk("ex1_r_const", 32'(r), 32'b110);
    release_out();

    send(7'b1111111, 4'b1011);
    wait_result(1'b1, 7'b1111111, 4'b1011);
    chk("rt1_q_const", 32'(q), 32'b0001101);
    release_out();

    send(7'b1111111, 4'b1101);
    wait_result(1'b1, 7'b1111111, 4'b1101);
    chk("rt2_q_const", 32'(q), 32'b0001011);
    release_out();

    send(7'b1100101, 4'b0001);
    wait_result(1'b1, 7'b1100101, 4'b0001);
    chk("b1_q_const", 32'(q), 32'b1100101);
    release_out();

    send(7'b0000001, 4'b0011);
    wait_result(1'b1, 7'b0000001, 4'b0011);
    release_out();

    // Zero divisor: result is visible right after the accept edge.
    send(7'h55, 4'b0000);
    wait_result(1'b1, 7'h55, 4'b0000);
    chk("dbz_const", 32'(div_by_zero), 32'd1);
    release_out();

    send(7'b1010101, 4'b1011);
    wait_result(1'b1, 7'b1010101, 4'b1011);
    chk("dbz_cleared", 32'(div_by_zero), 32'd0);
    hq = q;
    hr = r;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 7'h7F;
      b = 4'b0001;
      @(posedge clk);
      #1 chk("bp_q_stable", 32'(q), 32'(hq));
      chk("bp_r_stable", 32'(r), 32'(hr));
      chk("bp_dbz_stable", 32'(div_by_zero), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_out();

    // Async reset while the divider is mid-DIV.
    send(7'b1100101, 4'b0001);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_r", 32'(r), 32'd0);
    chk("arst_dbz", 32'(div_by_zero), 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;

    send(7'b1010101, 4'b1011);
    wait_result(1'b1, 7'b1010101, 4'b1011);
    chk("post_rst_q_const", 32'(q), 32'b0001001);
    chk("post_rst_r_const", 32'(r), 32'b110);
    release_out();

    // Every a/b pair, visited in a per-run scrambled order.
    ra = AW'($urandom_range(0, (1 << AW) - 1));
    rb = DW'($urandom_range(0, (1 << DW) - 1));
    for (int ai = 0; ai < (1 << AW); ai++) begin
      for (int bi = 0; bi < (1 << DW); bi++) begin
        send(AW'(ai) ^ ra, DW'(bi) ^ rb);
        wait_result(1'b1, AW'(ai) ^ ra, DW'(bi) ^ rb);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 release_out();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
